// File: rtl/thread_fetch_unit.sv
// ---------------------------------------------------------------------------
// thread_fetch_unit
//
// Per-thread instruction fetch stage placed after the thread scheduler.
// It accepts a thread ID, reads that thread's program counter and issues one
// instruction-memory read. The returned word goes to decode over a
// valid/ready handshake, and then the thread's PC advances by one.
//
// Optional feature (macro FETCH_HALT_DETECT_EN):
//   A captured word whose top nibble is 4'hF is treated as a HALT. It is
//   still delivered to decode. On its handshake the thread's sticky
//   thread_done bit is set and its PC is left unchanged. When the macro is
//   not defined, thread_done is constant 0.
//
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   launch, start_pc  : load every PC with start_pc and clear thread_done
//                       (honoured in IDLE only)
//   sched_valid/ready : scheduler handshake; sched_thread is the offered ID
//   mem_req_*         : instruction-memory read request (valid/ready, addr)
//   mem_rsp_*         : instruction-memory read response (valid, data)
//   instr_*           : fetched word to decode (valid/ready, data, thread, pc)
//   thread_done       : sticky per-thread halted flags
// ---------------------------------------------------------------------------
module thread_fetch_unit #(
  parameter int NUM_THREADS     = 4,
  parameter int THREAD_ID_WIDTH = 3,
  parameter int PC_WIDTH        = 8,
  parameter int INSTR_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       launch,
  input  logic [PC_WIDTH-1:0]        start_pc,
  input  logic                       sched_valid,
  input  logic [THREAD_ID_WIDTH-1:0] sched_thread,
  output logic                       sched_ready,
  output logic                       mem_req_valid,
  output logic [PC_WIDTH-1:0]        mem_req_addr,
  input  logic                       mem_req_ready,
  input  logic                       mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]     mem_rsp_data,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [INSTR_WIDTH-1:0]     instr_data,
  output logic [THREAD_ID_WIDTH-1:0] instr_thread,
  output logic [PC_WIDTH-1:0]        instr_pc,
  output logic [NUM_THREADS-1:0]     thread_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [PC_WIDTH-1:0]        pc_r [NUM_THREADS];
  logic [NUM_THREADS-1:0]     done_r;

  // Latched request (thread and PC) and captured response word.
  logic [THREAD_ID_WIDTH-1:0] tid_p0;
  logic [PC_WIDTH-1:0]        pc_p0;
  logic [INSTR_WIDTH-1:0]     data_p1;

  logic [PC_WIDTH-1:0]        sel_pc;
  logic                       sel_hit;
  logic                       sel_done;
  logic                       accept;
  logic                       start_fetch;
  logic                       out_fire;
  logic                       do_launch;
  logic                       is_halt;

  // PC advance, wrapping modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(1);
  endfunction

  // Look up the offered thread. IDs >= NUM_THREADS match no entry, so
  // sel_hit stays low and the offer is consumed without a fetch.
  always_comb begin
    sel_pc   = '0;
    sel_hit  = 1'b0;
    sel_done = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (sched_thread == THREAD_ID_WIDTH'(i)) begin
        sel_hit  = 1'b1;
        sel_pc   = pc_r[i];
        sel_done = done_r[i];
      end
    end
  end

  assign accept      = (state == S_IDLE) && sched_valid && sched_ready;
  assign start_fetch = accept && sel_hit && !sel_done;
  assign out_fire    = (state == S_OUT) && instr_ready;
  assign do_launch   = (state == S_IDLE) && launch;

`ifdef FETCH_HALT_DETECT_EN
  assign is_halt = (data_p1[INSTR_WIDTH-1 -: 4] == 4'hF);
`else
  assign is_halt = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_fetch)   state_nxt = S_REQ;
      S_REQ:  if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT: if (mem_rsp_valid) state_nxt = S_OUT;
      S_OUT:  if (instr_ready)   state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; launch takes priority over a scheduler offer.
  always_comb begin
    sched_ready   = (state == S_IDLE) && !launch && !reset;
    mem_req_valid = (state == S_REQ);
    instr_valid   = (state == S_OUT);
  end

  assign mem_req_addr = pc_p0;
  assign instr_pc     = pc_p0;
  assign instr_thread = tid_p0;
  assign instr_data   = data_p1;

  // Stage p0: latch thread and PC on a fetch-starting accept.
  // Stage p1: capture the memory response in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      tid_p0  <= '0;
      pc_p0   <= '0;
      data_p1 <= '0;
      for (int i = 0; i < NUM_THREADS; i++) pc_r[i] <= '0;
    end else begin
      if (start_fetch) begin
        tid_p0 <= sched_thread;
        pc_p0  <= sel_pc;
      end
      if ((state == S_WAIT) && mem_rsp_valid) begin
        data_p1 <= mem_rsp_data;
      end
      if (do_launch) begin
        for (int i = 0; i < NUM_THREADS; i++) pc_r[i] <= start_pc;
      end else if (out_fire && !is_halt) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
          if (tid_p0 == THREAD_ID_WIDTH'(i)) pc_r[i] <= pc_inc(pc_r[i]);
        end
      end
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r <= '0;
    end else if (do_launch) begin
      done_r <= '0;
    end else if (out_fire && is_halt) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (tid_p0 == THREAD_ID_WIDTH'(i)) done_r[i] <= 1'b1;
      end
    end
  end
`else
  assign done_r = '0;
`endif

  assign thread_done = done_r;

endmodule

// File: doc/thread_fetch_unit.md
# thread_fetch_unit

Per-thread instruction fetch stage sitting directly downstream of the thread `scheduler`. It accepts the thread ID the scheduler selects, keeps a program counter per thread, and issues one instruction-memory read for that thread. It returns the fetched word to decode over a valid/ready handshake. A per-thread `thread_done` mask is fed back so upstream logic can clear the thread from `active_threads`.

## Interface
Parameters:
- `NUM_THREADS`, 4: number of hardware threads.
- `THREAD_ID_WIDTH`, 3: width of thread IDs; must satisfy 2^`THREAD_ID_WIDTH` >= `NUM_THREADS`.
- `PC_WIDTH`, 8: program counter and instruction address width.
- `INSTR_WIDTH`, 16: instruction word width; must be >= 4.

Ports:
- `clk` in 1: single clock; all logic updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `launch` in 1: one-cycle pulse; loads every PC with `start_pc` and clears `thread_done`.
- `start_pc` in `PC_WIDTH`: launch PC value.
- `sched_valid` in 1: scheduler offers a thread.
- `sched_thread` in `THREAD_ID_WIDTH`: thread ID offered by the scheduler.
- `sched_ready` out 1: unit can accept a thread this cycle.
- `mem_req_valid` out 1: instruction-memory read request.
- `mem_req_addr` out `PC_WIDTH`: read address.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_rsp_valid` in 1: read data valid.
- `mem_rsp_data` in `INSTR_WIDTH`: read data.
- `instr_valid` out 1: fetched instruction available to decode.
- `instr_ready` in 1: decode accepts the instruction.
- `instr_data` out `INSTR_WIDTH`: fetched instruction word.
- `instr_thread` out `THREAD_ID_WIDTH`: owning thread of `instr_data`.
- `instr_pc` out `PC_WIDTH`: PC that `instr_data` was fetched from.
- `thread_done` out `NUM_THREADS`: sticky per-thread halted flags.

## Operation
- FSM has four states: IDLE, REQ, WAIT, OUT.
- **IDLE:**
  - `sched_ready` = 1 unless `launch` = 1.
  - On `sched_valid` & `sched_ready`, latch the thread ID and that thread's PC.
  - If the ID >= `NUM_THREADS`, or the thread's `thread_done` bit is set, the offer is consumed and the FSM stays in IDLE; no fetch is issued.
  - Otherwise go to REQ.
- **REQ:** `mem_req_valid` = 1 and `mem_req_addr` = latched PC, both held stable until `mem_req_ready`; then go to WAIT.
- **WAIT:** on `mem_rsp_valid`, capture `mem_rsp_data` and go to OUT. `mem_rsp_valid` in any other state is ignored.
- **OUT:**
  - `instr_valid` = 1, with `instr_data`, `instr_thread` and `instr_pc` held stable until `instr_ready`.
  - On the handshake, pc[tid] <= pc[tid] + 1, wrapping modulo 2^`PC_WIDTH` (0xFF -> 0x00 at default width).
  - Then return to IDLE.
- `launch` is honoured only in IDLE; in other states it is ignored.
- `launch` and `sched_valid` in the same IDLE cycle: `launch` wins and no thread is accepted.
- Per-thread PCs live in registers; only the thread being fetched is updated.

## Timing
- **Reset:**
  - FSM in IDLE; all PCs 0; `thread_done` 0.
  - `mem_req_valid`, `instr_valid`, `mem_req_addr`, `instr_data`, `instr_thread`, `instr_pc` all 0.
  - `sched_ready` is 0 while `reset` is high.
- **Mid-operation reset:** `reset` asserted in any state returns to IDLE on the next edge. Any outstanding memory response is dropped.
- **Minimum latency**, with `mem_req_ready` = 1 and the response one cycle after the request:
  - Cycle 0: accept.
  - Cycle 1: `mem_req_valid` high.
  - Cycle 2: `mem_rsp_valid` sampled.
  - Cycle 3: `instr_valid` high.
- **Throughput:** one instruction per 4 cycles at best. `sched_ready` is low in REQ, WAIT and OUT.
- **Backpressure:** `mem_req_ready` or `instr_ready` held low stalls indefinitely with outputs held stable.
- **Launch timing:** PCs and `thread_done` take their new values on the edge after the `launch` cycle.

## Configuration
- Macro `FETCH_HALT_DETECT_EN`.
- **Defined:**
  - A captured word whose top 4 bits are 4'hF is a HALT.
  - The word is still delivered to decode normally.
  - On its OUT handshake, `thread_done[tid]` is set and that thread's PC is not incremented.
- **Undefined:** `thread_done` is constant 0 and all words are fetched normally.

## Test plan
- **Basic fetch:** reset, `launch` with `start_pc`=0x10, offer thread 2, memory returns 0x1234 one cycle after the request. Expect `mem_req_addr`=0x10, then `instr_data`=0x1234, `instr_thread`=2, `instr_pc`=0x10. A second offer of thread 2 fetches address 0x11.
- **Backpressure:** hold `mem_req_ready`=0 for 5 cycles, then `instr_ready`=0 for 3 cycles. Expect address and instruction outputs stable throughout, exactly one PC increment, and `sched_ready`=0 until the return to IDLE.
- **Wrap and invalid ID:** set the thread 1 PC to 0xFF via `start_pc` and fetch. Expect the next fetch of thread 1 at 0x00. An offer of ID 5 (with `NUM_THREADS`=4) is consumed with no `mem_req_valid`.
- **Halt (macro defined):** thread 0 fetches 0xF000. Expect it delivered to decode, then `thread_done`=4'b0001. A later offer of thread 0 issues no request. `launch` clears `thread_done` to 0.
- **Reset mid-fetch:** assert `reset` in WAIT. Expect IDLE, PCs 0 and no `instr_valid`. A late `mem_rsp_valid` after reset is ignored.
- **Simultaneous events:** `launch` and `sched_valid` in the same IDLE cycle. Expect no accept and all PCs equal to `start_pc`. `launch` asserted during WAIT has no effect.
